// File: rtl/sofa_plus_scan_ctrl.sv
// Scan-chain sequencer for a chain of sofa_plus_dff cells: serial load, optional
// functional capture, serial unload into a parallel response word.
module sofa_plus_scan_ctrl #(
    parameter int CHAIN_LEN   = 32,
    parameter int CAPT_CYCLES = 1,
    parameter int CNT_W       = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 capture_en,
    input  logic [CHAIN_LEN-1:0] vec_in,
    input  logic                 scan_do,
    output logic                 scan_en,
    output logic                 scan_di,
    output logic                 busy,
    output logic                 done,
    output logic                 resp_valid,
    output logic [CHAIN_LEN-1:0] resp_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAPT_LAST = CNT_W'(CAPT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic                 cap_q, cap_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_di_q, scan_di_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 resp_valid_q, resp_valid_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        resp_d       = resp_q;
        cap_d        = cap_q;
        scan_en_d    = scan_en_q;
        scan_di_d    = scan_di_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        resp_valid_d = resp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    cnt_d        = '0;
                    shift_d      = vec_in;
                    cap_d        = capture_en;
                    scan_en_d    = 1'b1;
                    scan_di_d    = vec_in[0];
                    busy_d       = 1'b1;
                    resp_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                // scan_di is registered, so it is fed one bit ahead of the shift
                cnt_d     = cnt_q + CNT_W'(1);
                shift_d   = shift_q >> 1;
                scan_di_d = shift_q[1];
                if (cnt_q == LOAD_LAST) begin
                    cnt_d     = '0;
                    scan_di_d = 1'b0;
                    if (cap_q) begin
                        state_d   = S_CAPTURE;
                        scan_en_d = 1'b0;
                    end else begin
                        state_d = S_UNLOAD;
                    end
                end
            end
            S_CAPTURE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CAPT_LAST) begin
                    cnt_d     = '0;
                    state_d   = S_UNLOAD;
                    scan_en_d = 1'b1;
                end
            end
            S_UNLOAD: begin
                // Response is assembled in shift_q and only published on completion,
                // so an aborted unload leaves resp_out untouched.
                cnt_d   = cnt_q + CNT_W'(1);
                shift_d = {scan_do, shift_q[CHAIN_LEN-1:1]};
                if (cnt_q == LOAD_LAST) begin
                    cnt_d        = '0;
                    state_d      = S_DONE;
                    scan_en_d    = 1'b0;
                    done_d       = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_d       = {scan_do, shift_q[CHAIN_LEN-1:1]};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort && (state_q == S_LOAD || state_q == S_CAPTURE || state_q == S_UNLOAD)) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            shift_d      = shift_q;
            resp_d       = resp_q;
            scan_en_d    = 1'b0;
            scan_di_d    = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            resp_q       <= '0;
            cap_q        <= 1'b0;
            scan_en_q    <= 1'b0;
            scan_di_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            resp_q       <= resp_d;
            cap_q        <= cap_d;
            scan_en_q    <= scan_en_d;
            scan_di_q    <= scan_di_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign scan_en    = scan_en_q;
    assign scan_di    = scan_di_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign resp_valid = resp_valid_q;
    assign resp_out   = resp_q;

endmodule
